morse_key_decoder: RTL and testbench

- Receive-side counterpart to the game's Morse number presentation: the player keys a digit in Morse on a single button, and this block times each press and release.
- It classifies each press as dot or dash, collects the five symbols of a Morse digit, and decodes them to a 4-bit value.
- It sits between the debounced key button and gamecontrol, as an alternative source for user_input, with a one-cycle valid strobe.

---
 rtl/morse_key_decoder_if.sv | 22 ++
 rtl/morse_key_decoder.sv | 172 +++++++++++++++++
 tb/tb_morse_key_decoder.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/morse_key_decoder_if.sv
// Key-side inputs and decoded-digit outputs of the Morse key decoder.
// The master drives the key, the tick and the clear; the slave is the decoder.
interface morse_key_decoder_if;
  logic       tick;
  logic       key;
  logic       clear;
  logic [3:0] digit;
  logic       valid;
  logic       error;
  logic [2:0] sym_count;
  logic       busy;

  modport master (
    output tick, key, clear,
    input  digit, valid, error, sym_count, busy
  );

  modport slave (
    input  tick, key, clear,
    output digit, valid, error, sym_count, busy
  );
endinterface

// File: rtl/morse_key_decoder.sv
// Times Morse key presses and releases, classifies each press as a dot or a dash,
// and decodes a five-symbol Morse digit to a 4-bit value with valid/error pulses.
module morse_key_decoder #(
  parameter int DASH_TICKS      = 3,
  parameter int MAX_PRESS_TICKS = 15,
  parameter int GAP_TICKS       = 7
) (
  input logic                clk,
  input logic                rst,
  morse_key_decoder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, PRESS, GAP, DECODE, ERR, HOLD} state_e;

  localparam logic [3:0] DashLimit  = 4'(DASH_TICKS);
  localparam logic [3:0] PressLimit = 4'(MAX_PRESS_TICKS);
  localparam logic [3:0] GapLimit   = 4'(GAP_TICKS);

  state_e     state_q, state_d;
  logic [3:0] press_cnt_q, press_cnt_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic [4:0] pattern_q, pattern_d;
  logic [2:0] sym_count_q, sym_count_d;
  logic [3:0] digit_q, digit_d;
  logic       valid_q, valid_d;
  logic       error_q, error_d;

  logic [3:0] press_inc;
  logic [3:0] gap_inc;
  logic       is_dash;
  logic       pattern_ok;
  logic [3:0] pattern_value;

  // Counters saturate at all-ones so a long press or gap can never wrap around.
  assign press_inc = (press_cnt_q == 4'hF) ? press_cnt_q : press_cnt_q + 4'd1;
  assign gap_inc   = (gap_cnt_q == 4'hF) ? gap_cnt_q : gap_cnt_q + 4'd1;
  assign is_dash   = (press_cnt_q >= DashLimit);

  always_comb begin
    pattern_ok    = 1'b1;
    pattern_value = 4'd0;
    case (pattern_q)
      5'b01111: pattern_value = 4'd1;
      5'b00111: pattern_value = 4'd2;
      5'b00011: pattern_value = 4'd3;
      5'b00001: pattern_value = 4'd4;
      5'b00000: pattern_value = 4'd5;
      5'b10000: pattern_value = 4'd6;
      5'b11000: pattern_value = 4'd7;
      5'b11100: pattern_value = 4'd8;
      5'b11110: pattern_value = 4'd9;
      5'b11111: pattern_value = 4'd0;
      default:  pattern_ok    = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      press_cnt_q <= 4'd0;
      gap_cnt_q   <= 4'd0;
      pattern_q   <= 5'd0;
      sym_count_q <= 3'd0;
      digit_q     <= 4'd0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      press_cnt_q <= press_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      pattern_q   <= pattern_d;
      sym_count_q <= sym_count_d;
      digit_q     <= digit_d;
      valid_q     <= valid_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    press_cnt_d = press_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    pattern_d   = pattern_q;
    sym_count_d = sym_count_q;
    digit_d     = digit_q;
    valid_d     = 1'b0;
    error_d     = 1'b0;

    if (bus.clear) begin
      state_d     = IDLE;
      press_cnt_d = 4'd0;
      gap_cnt_d   = 4'd0;
      pattern_d   = 5'd0;
      sym_count_d = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.key) begin
            state_d     = PRESS;
            press_cnt_d = 4'd0;
          end
        end
        // Release is checked first, so a tick in the release cycle is not counted.
        PRESS: begin
          if (!bus.key) begin
            pattern_d   = {pattern_q[3:0], is_dash};
            sym_count_d = sym_count_q + 3'd1;
            if (sym_count_q == 3'd4) begin
              state_d = DECODE;
            end else begin
              state_d   = GAP;
              gap_cnt_d = 4'd0;
            end
          end else if (bus.tick) begin
            press_cnt_d = press_inc;
            if (press_inc >= PressLimit) begin
              state_d     = ERR;
              pattern_d   = 5'd0;
              sym_count_d = 3'd0;
            end
          end
        end
        GAP: begin
          if (bus.key) begin
            state_d     = PRESS;
            press_cnt_d = 4'd0;
          end else if (bus.tick) begin
            gap_cnt_d = gap_inc;
            if (gap_inc >= GapLimit) begin
              state_d     = ERR;
              pattern_d   = 5'd0;
              sym_count_d = 3'd0;
            end
          end
        end
        DECODE: begin
          if (pattern_ok) begin
            digit_d = pattern_value;
            valid_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
          state_d     = IDLE;
          pattern_d   = 5'd0;
          sym_count_d = 3'd0;
        end
        // A key still held after an error parks in HOLD so it cannot start a digit.
        ERR: begin
          error_d = 1'b1;
          state_d = bus.key ? HOLD : IDLE;
        end
        HOLD: begin
          if (!bus.key) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bus.digit     = digit_q;
    bus.valid     = valid_q;
    bus.error     = error_q;
    bus.sym_count = sym_count_q;
    bus.busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_morse_key_decoder.sv
// Directed bench for the Morse key decoder: keys known digits, bad patterns,
// timeouts, clear and reset, and compares outputs against hand-computed values.
module tb_morse_key_decoder;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   validSeen = 0;
  int   errorSeen = 0;

  always #5 clk = ~clk;

  morse_key_decoder_if bus ();

  morse_key_decoder #(
    .DASH_TICKS     (3),
    .MAX_PRESS_TICKS(15),
    .GAP_TICKS      (7)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Counts pulse cycles just after each edge so tests can verify one-cycle pulses.
  always @(posedge clk) begin
    #1;
    if (bus.valid === 1'b1) validSeen++;
    if (bus.error === 1'b1) errorSeen++;
  end

  task automatic step(input logic k, input logic t);
    bus.key  = k;
    bus.tick = t;
    @(negedge clk);
  endtask

  task automatic pressSym(input int n);
    step(1'b1, 1'b0);
    repeat (n) step(1'b1, 1'b1);
    step(1'b0, 1'b0);
  endtask

  task automatic gapTicks(input int n);
    repeat (n) step(1'b0, 1'b1);
  endtask

  task automatic keyDigit(input int lens[5]);
    for (int i = 0; i < 5; i++) begin
      pressSym(lens[i]);
      if (i < 4) gapTicks(2);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; bus.clear = 1'b0;
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    checks++; if (bus.digit !== 4'd0) begin failures++; $display("[TB] FAIL reset_digit got=%0d exp=0", bus.digit); end
    checks++; if (bus.valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%0b exp=0", bus.valid); end
    checks++; if (bus.error !== 1'b0) begin failures++; $display("[TB] FAIL reset_error got=%0b exp=0", bus.error); end
    checks++; if (bus.sym_count !== 3'd0) begin failures++; $display("[TB] FAIL reset_sym got=%0d exp=0", bus.sym_count); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%0b exp=0", bus.busy); end
    rst = 1'b0;
    step(1'b0, 1'b0);
  endtask

  task automatic test_digit_two;
    int lens[5] = '{1, 1, 4, 4, 4};
    int v0, e0;
    v0 = validSeen; e0 = errorSeen;
    for (int i = 0; i < 5; i++) begin
      pressSym(lens[i]);
      checks++;
      if (bus.sym_count !== 3'(i + 1)) begin failures++; $display("[TB] FAIL two_sym%0d got=%0d exp=%0d", i, bus.sym_count, i + 1); end
      if (i < 4) gapTicks(2);
    end
    checks++; if (bus.valid !== 1'b0) begin failures++; $display("[TB] FAIL two_early_valid got=%0b exp=0", bus.valid); end
    step(1'b0, 1'b0);
    checks++; if (bus.valid !== 1'b1) begin failures++; $display("[TB] FAIL two_valid got=%0b exp=1", bus.valid); end
    checks++; if (bus.digit !== 4'd2) begin failures++; $display("[TB] FAIL two_digit got=%0d exp=2", bus.digit); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL two_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.sym_count !== 3'd0) begin failures++; $display("[TB] FAIL two_sym_idle got=%0d exp=0", bus.sym_count); end
    step(1'b0, 1'b0);
    checks++; if (bus.valid !== 1'b0) begin failures++; $display("[TB] FAIL two_valid_drop got=%0b exp=0", bus.valid); end
    checks++; if (validSeen - v0 != 1) begin failures++; $display("[TB] FAIL two_valid_count got=%0d exp=1", validSeen - v0); end
    checks++; if (errorSeen != e0) begin failures++; $display("[TB] FAIL two_error_count got=%0d exp=0", errorSeen - e0); end
  endtask

  task automatic test_zero_five;
    int v0;
    v0 = validSeen;
    keyDigit('{5, 5, 5, 5, 5});
    step(1'b0, 1'b0);
    checks++; if (bus.valid !== 1'b1) begin failures++; $display("[TB] FAIL zero_valid got=%0b exp=1", bus.valid); end
    checks++; if (bus.digit !== 4'd0) begin failures++; $display("[TB] FAIL zero_digit got=%0d exp=0", bus.digit); end
    step(1'b0, 1'b0);
    checks++; if (bus.valid !== 1'b0) begin failures++; $display("[TB] FAIL zero_valid_drop got=%0b exp=0", bus.valid); end
    keyDigit('{1, 1, 1, 1, 1});
    step(1'b0, 1'b0);
    checks++; if (bus.valid !== 1'b1) begin failures++; $display("[TB] FAIL five_valid got=%0b exp=1", bus.valid); end
    checks++; if (bus.digit !== 4'd5) begin failures++; $display("[TB] FAIL five_digit got=%0d exp=5", bus.digit); end
    step(1'b0, 1'b0);
    checks++; if (validSeen - v0 != 2) begin failures++; $display("[TB] FAIL zero_five_count got=%0d exp=2", validSeen - v0); end
  endtask

  task automatic test_invalid;
    int v0, e0;
    v0 = validSeen; e0 = errorSeen;
    keyDigit('{1, 4, 1, 4, 1});
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL inv_busy_decode got=%0b exp=1", bus.busy); end
    step(1'b0, 1'b0);
    checks++; if (bus.error !== 1'b1) begin failures++; $display("[TB] FAIL inv_error got=%0b exp=1", bus.error); end
    checks++; if (bus.valid !== 1'b0) begin failures++; $display("[TB] FAIL inv_valid got=%0b exp=0", bus.valid); end
    checks++; if (bus.digit !== 4'd5) begin failures++; $display("[TB] FAIL inv_digit got=%0d exp=5", bus.digit); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL inv_busy got=%0b exp=0", bus.busy); end
    step(1'b0, 1'b0);
    checks++; if (bus.error !== 1'b0) begin failures++; $display("[TB] FAIL inv_error_drop got=%0b exp=0", bus.error); end
    checks++; if (errorSeen - e0 != 1) begin failures++; $display("[TB] FAIL inv_error_count got=%0d exp=1", errorSeen - e0); end
    checks++; if (validSeen != v0) begin failures++; $display("[TB] FAIL inv_valid_count got=%0d exp=0", validSeen - v0); end
  endtask

  task automatic test_gap_timeout;
    pressSym(1);
    gapTicks(2);
    pressSym(1);
    gapTicks(6);
    checks++; if (bus.sym_count !== 3'd2) begin failures++; $display("[TB] FAIL gap6_sym got=%0d exp=2", bus.sym_count); end
    checks++; if (bus.error !== 1'b0) begin failures++; $display("[TB] FAIL gap6_error got=%0b exp=0", bus.error); end
    step(1'b0, 1'b1);
    checks++; if (bus.sym_count !== 3'd0) begin failures++; $display("[TB] FAIL gap7_sym got=%0d exp=0", bus.sym_count); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL gap7_busy got=%0b exp=1", bus.busy); end
    step(1'b0, 1'b0);
    checks++; if (bus.error !== 1'b1) begin failures++; $display("[TB] FAIL gap_error got=%0b exp=1", bus.error); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL gap_idle got=%0b exp=0", bus.busy); end
    step(1'b0, 1'b0);
    checks++; if (bus.error !== 1'b0) begin failures++; $display("[TB] FAIL gap_error_drop got=%0b exp=0", bus.error); end
  endtask

  task automatic test_stuck_key;
    step(1'b1, 1'b0);
    repeat (14) step(1'b1, 1'b1);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL stuck14_busy got=%0b exp=1", bus.busy); end
    checks++; if (bus.error !== 1'b0) begin failures++; $display("[TB] FAIL stuck14_error got=%0b exp=0", bus.error); end
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    checks++; if (bus.error !== 1'b1) begin failures++; $display("[TB] FAIL stuck_error got=%0b exp=1", bus.error); end
    repeat (5) step(1'b1, 1'b1);
    checks++; if (bus.error !== 1'b0) begin failures++; $display("[TB] FAIL hold_error got=%0b exp=0", bus.error); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL hold_busy got=%0b exp=1", bus.busy); end
    checks++; if (bus.sym_count !== 3'd0) begin failures++; $display("[TB] FAIL hold_sym got=%0d exp=0", bus.sym_count); end
    step(1'b0, 1'b0);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL hold_release got=%0b exp=0", bus.busy); end
    keyDigit('{1, 1, 4, 4, 4});
    step(1'b0, 1'b0);
    checks++; if (bus.valid !== 1'b1) begin failures++; $display("[TB] FAIL after_hold_valid got=%0b exp=1", bus.valid); end
    checks++; if (bus.digit !== 4'd2) begin failures++; $display("[TB] FAIL after_hold_digit got=%0d exp=2", bus.digit); end
    step(1'b0, 1'b0);
  endtask

  task automatic test_clear;
    int v0, e0;
    v0 = validSeen; e0 = errorSeen;
    pressSym(1); gapTicks(1);
    pressSym(1); gapTicks(1);
    pressSym(4); gapTicks(1);
    checks++; if (bus.sym_count !== 3'd3) begin failures++; $display("[TB] FAIL clr_pre_sym got=%0d exp=3", bus.sym_count); end
    bus.clear = 1'b1;
    step(1'b1, 1'b1);
    bus.clear = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL clr_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.sym_count !== 3'd0) begin failures++; $display("[TB] FAIL clr_sym got=%0d exp=0", bus.sym_count); end
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    checks++; if (bus.digit !== 4'd2) begin failures++; $display("[TB] FAIL clr_digit got=%0d exp=2", bus.digit); end
    checks++; if (validSeen != v0 || errorSeen != e0) begin failures++; $display("[TB] FAIL clr_pulses got=%0d/%0d exp=0/0", validSeen - v0, errorSeen - e0); end
  endtask

  task automatic test_reset_mid_press;
    pressSym(1); gapTicks(1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    checks++; if (bus.sym_count !== 3'd1) begin failures++; $display("[TB] FAIL rstmid_pre_sym got=%0d exp=1", bus.sym_count); end
    rst = 1'b1;
    step(1'b1, 1'b1);
    checks++; if (bus.digit !== 4'd0) begin failures++; $display("[TB] FAIL rstmid_digit got=%0d exp=0", bus.digit); end
    checks++; if (bus.sym_count !== 3'd0) begin failures++; $display("[TB] FAIL rstmid_sym got=%0d exp=0", bus.sym_count); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.valid !== 1'b0 || bus.error !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_pulses got=%0b%0b exp=00", bus.valid, bus.error); end
    rst = 1'b0;
    step(1'b0, 1'b0);
  endtask

  initial begin
    bus.key = 1'b0; bus.tick = 1'b0; bus.clear = 1'b0; rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_digit_two();
    test_zero_five();
    test_invalid();
    test_gap_timeout();
    test_stuck_key();
    test_clear();
    test_reset_mid_press();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
